uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART 8N1 receiver for the HACK UART_RX pin.
- Mirrors the UART sender that the HACK-level bench drives: 115200 baud at CLK = 100 MHz, one start bit, 8 data bits LSB first, one stop bit, line idle high.
- Presents received bytes as a HACK memory-mapped 16-bit word. The CPU polls it and clears it by writing.

Parameters:
- BAUD_DIV, 868, CLK cycles per bit (100 MHz / 115200). Legal range 4..65535.
- FIFO_DEPTH, 4, entries in the receive FIFO. Power of two. Used only with UART_RX_FIFO_EN.

Ports:
- CLK  in  1  system clock, all logic on posedge
- RST_N  in  1  synchronous active-low reset, sampled on posedge CLK
- RX  in  1  asynchronous serial input, idle high
- load  in  1  CPU write strobe; clears (pops) the current byte
- out  out  16  0x8000 when empty, else {8'h00, byte}
- FERR  out  1  one-cycle pulse on framing error
- OVR  out  1  one-cycle pulse when a good byte is dropped because storage is full

Behaviour:
- Reset (RST_N=0 at posedge):
  - FSM goes to IDLE; baud and bit counters = 0.
  - Synchroniser flops = 1.
  - out = 0x8000, FERR = 0, OVR = 0; FIFO pointers = 0.
- Reset mid-frame aborts the frame and discards the partial byte.
- Input sync: RX passes through 2 flops (rx_s) before any use. Total sync latency is 2 cycles.
- FSM states:
  - IDLE: on rx_s==0, go to START and set baud counter = 0.
  - START: count to BAUD_DIV/2 - 1 (integer divide), then sample rx_s.
    - 0: go to DATA, bit counter = 0, baud counter = 0.
    - 1: glitch; return to IDLE with no output change.
  - DATA: each time the baud counter reaches BAUD_DIV-1, sample rx_s into shift[bit] (LSB first) and reset the counter. After bit 7 go to STOP.
  - STOP: at BAUD_DIV-1 sample rx_s.
    - 1: commit the byte, go to IDLE.
    - 0: FERR=1 for one cycle, byte discarded, go to IDLE. A new start is not accepted until rx_s returns high.
- Commit timing: out reflects the new byte on the posedge after the stop-bit sample. Total from the RX stop-bit midpoint is 2 sync + 1 = 3 cycles.
- Storage without FIFO: a single holding register.
  - Commit while empty: store the byte.
  - Commit while full and load=0: drop the new byte, OVR pulse, keep the old byte.
  - load=1 while empty: no effect.
  - load=1 while full: out = 0x8000 next cycle.
  - load and commit in the same cycle: the old byte is cleared and the new byte is stored. out = new byte, no OVR.
- Frame rate: back-to-back frames need no idle gap. IDLE detects a start edge in the cycle after the stop sample.
- Widths: baud counter is 16 bits; bit counter is 3 bits. Neither counter wraps except by explicit reset to 0.

Optional Feature:
- Macro: UART_RX_FIFO_EN.
- Defined: the holding register is replaced by a FIFO_DEPTH-entry FIFO.
  - out shows the head entry, or 0x8000 when the FIFO is empty.
  - load pops the head. Pop on empty is ignored.
  - Commit pushes. Commit when full with load=0 drops the byte and pulses OVR.
  - Simultaneous pop and push when full: both occur, count unchanged, no OVR.
  - Read and write pointers wrap modulo FIFO_DEPTH. Full/empty is tracked with an extra pointer bit.
- Undefined: single holding register as above. No FIFO logic is synthesised.

Test Plan:
- Reset then idle: RST_N low 3 cycles, RX=1 for 20 bit times -> out=0x8000; FERR and OVR never asserted.
- 'R' then load, with BAUD_DIV=868:
  - Send 0x52 -> out=0x0052 exactly 3 cycles after the stop-bit midpoint.
  - Pulse load -> out=0x8000 next cycle.
  - Send 'X' -> out=0x0058.
- Glitch and framing:
  - RX low for 100 cycles then high -> FSM returns to IDLE, out unchanged.
  - Send 0xA5 with stop bit 0 -> FERR one-cycle pulse, out stays 0x8000.
- Overrun and same-cycle load (no FIFO):
  - Send 0x11 then 0x22 without load -> OVR pulse, out=0x0011.
  - Repeat with load asserted in the commit cycle of 0x22 -> out=0x0022, no OVR.
- FIFO (UART_RX_FIFO_EN, FIFO_DEPTH=4):
  - Send 0x01..0x05 back-to-back -> OVR on 0x05.
  - Four loads yield out = 0x0001, 0x0002, 0x0003, 0x0004, then 0x8000.
- Reset mid-frame: assert RST_N low during data bit 4 of 0x3C -> out=0x8000. The next full frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// CPU-facing bus of the HACK UART receiver: serial line in, polled status/data word out.
interface uart_rx_if;
  logic        RX;
  logic        load;
  logic [15:0] out;
  logic        FERR;
  logic        OVR;

  modport master (
    output RX,
    output load,
    input  out,
    input  FERR,
    input  OVR
  );

  modport slave (
    input  RX,
    input  load,
    output out,
    output FERR,
    output OVR
  );
endinterface

// File: rtl/uart_rx.sv
// UART 8N1 receiver presenting bytes as a polled HACK word (0x8000 = empty).
// Define UART_RX_FIFO_EN to replace the single holding register by a FIFO_DEPTH-entry FIFO.
module uart_rx #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     CLK,
  input  logic     RST_N,
  uart_rx_if.slave bus
);

  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_START   = 2'd1;
  localparam logic [1:0]  ST_DATA    = 2'd2;
  localparam logic [1:0]  ST_STOP    = 2'd3;
  localparam logic [15:0] HALF_LAST  = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] BIT_LAST   = 16'(BAUD_DIV - 1);
  localparam logic [15:0] EMPTY_WORD = 16'h8000;
  // An illegal parameterisation leaves the receiver permanently idle instead of misbehaving.
  localparam bit CFG_OK = (BAUD_DIV >= 4) && (BAUD_DIV <= 65535) &&
                          (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

  function automatic logic [15:0] byte_word(input logic [7:0] b);
    byte_word = {8'h00, b};
  endfunction

  logic        rx_meta_r;
  logic        rx_s_r;
  logic [1:0]  state_r;
  logic [1:0]  state_n;
  logic [15:0] baud_r;
  logic [15:0] baud_n;
  logic [2:0]  bit_r;
  logic [2:0]  bit_n;
  logic [7:0]  shift_r;
  logic [7:0]  shift_n;
  logic        armed_r;
  logic        armed_n;
  logic        commit_s;
  logic        ferr_s;
  logic        ferr_r;
  logic        ovr_r;
  logic [15:0] out_r;

  // two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_meta_r <= 1'b1;
      rx_s_r    <= 1'b1;
    end else begin
      rx_meta_r <= bus.RX;
      rx_s_r    <= rx_meta_r;
    end
  end

  // frame FSM next-state: start qualification, mid-bit sampling, stop check
  always_comb begin
    state_n  = state_r;
    baud_n   = baud_r;
    bit_n    = bit_r;
    shift_n  = shift_r;
    armed_n  = armed_r;
    commit_s = 1'b0;
    ferr_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // after a framing error the line must be seen high before a new start counts
        if (rx_s_r) begin
          armed_n = 1'b1;
        end else begin
          armed_n = armed_r;
        end
        if (!rx_s_r && armed_r && CFG_OK) begin
          state_n = ST_START;
          baud_n  = 16'd0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_r == HALF_LAST) begin
          baud_n = 16'd0;
          if (!rx_s_r) begin
            state_n = ST_DATA;
            bit_n   = 3'd0;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          baud_n = baud_r + 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_r == BIT_LAST) begin
          baud_n         = 16'd0;
          shift_n[bit_r] = rx_s_r;
          if (bit_r == 3'd7) begin
            state_n = ST_STOP;
          end else begin
            bit_n = bit_r + 3'd1;
          end
        end else begin
          baud_n = baud_r + 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_r == BIT_LAST) begin
          baud_n  = 16'd0;
          state_n = ST_IDLE;
          if (rx_s_r) begin
            commit_s = 1'b1;
          end else begin
            ferr_s  = 1'b1;
            armed_n = 1'b0;
          end
        end else begin
          baud_n = baud_r + 16'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        baud_n  = 16'd0;
        bit_n   = 3'd0;
      end
    endcase
  end

  // frame FSM state registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
      baud_r  <= 16'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      armed_r <= 1'b1;
      ferr_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      baud_r  <= baud_n;
      bit_r   <= bit_n;
      shift_r <= shift_n;
      armed_r <= armed_n;
      ferr_r  <= ferr_s;
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem_r [FIFO_DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [AW:0] wr_ptr_n;
  logic [AW:0] rd_ptr_n;
  logic        empty_s;
  logic        full_s;
  logic        pop_s;
  logic        push_s;
  logic        drop_s;
  logic [15:0] head_n;

  // FIFO control; head_n is the word shown once this cycle's push/pop have landed
  always_comb begin
    empty_s  = (wr_ptr_r == rd_ptr_r);
    full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s    = bus.load && !empty_s;
    push_s   = commit_s && (!full_s || pop_s);
    drop_s   = commit_s && full_s && !pop_s;
    wr_ptr_n = wr_ptr_r + {{AW{1'b0}}, push_s};
    rd_ptr_n = rd_ptr_r + {{AW{1'b0}}, pop_s};
    if (wr_ptr_n == rd_ptr_n) begin
      head_n = EMPTY_WORD;
    end else if (rd_ptr_n == wr_ptr_r) begin
      // the new head is the byte being pushed right now, not yet in the array
      head_n = byte_word(shift_r);
    end else begin
      head_n = byte_word(mem_r[rd_ptr_n[AW-1:0]]);
    end
  end

  // FIFO storage array
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
    end
  end

  // FIFO pointers and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      out_r    <= EMPTY_WORD;
      ovr_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_n;
      rd_ptr_r <= rd_ptr_n;
      out_r    <= head_n;
      ovr_r    <= drop_s;
    end
  end
`else
  logic [15:0] hold_n;
  logic        drop_s;

  // single holding register: same-cycle clear and commit keeps the new byte
  always_comb begin
    hold_n = out_r;
    drop_s = 1'b0;
    if (commit_s) begin
      if (out_r[15] || bus.load) begin
        hold_n = byte_word(shift_r);
      end else begin
        drop_s = 1'b1;
      end
    end else if (bus.load) begin
      hold_n = EMPTY_WORD;
    end else begin
      hold_n = out_r;
    end
  end

  // holding register and overrun pulse
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_r <= EMPTY_WORD;
      ovr_r <= 1'b0;
    end else begin
      out_r <= hold_n;
      ovr_r <= drop_s;
    end
  end
`endif

  assign bus.out  = out_r;
  assign bus.FERR = ferr_r;
  assign bus.OVR  = ovr_r;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: timed frames feed a queue-based storage model, a monitor checks every output change.
module tb_uart_rx;
  localparam int B     = 20;
  localparam int H     = B / 2;
  localparam int DEPTH = 4;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  typedef struct { int cyc; int kind; logic [15:0] val; } ev_t;
  typedef struct { int cyc; logic [7:0] b; bit good; } fr_t;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  uart_rx_if bus();

  uart_rx #(.BAUD_DIV(B), .FIFO_DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int         cyc         = 0;
  int         vectors     = 0;
  int         miscompares = 0;
  bit         mon_en      = 1'b0;
  ev_t        exp_q[$];
  fr_t        sched_q[$];
  logic [7:0] store_q[$];
  logic [15:0] model_out  = 16'h8000;
  logic [15:0] prev_out   = 16'h8000;

  // Reference model: frames commit 9.5 bit times + 3 cycles after the start edge.
  task automatic model_step();
    bit ferr = 1'b0;
    bit ovr  = 1'b0;
    logic [15:0] w;
    fr_t f;
    if (RST_N !== 1'b1) begin
      store_q.delete();
      sched_q.delete();
    end else begin
      if (bus.load === 1'b1 && store_q.size() > 0) void'(store_q.pop_front());
      if (sched_q.size() > 0 && sched_q[0].cyc == cyc) begin
        f = sched_q.pop_front();
        if (!f.good) ferr = 1'b1;
        else if (store_q.size() < CAP) store_q.push_back(f.b);
        else ovr = 1'b1;
      end
    end
    w = (store_q.size() > 0) ? {8'h00, store_q[0]} : 16'h8000;
    if (w !== model_out) begin
      exp_q.push_back('{cyc, 0, w});
      model_out = w;
    end
    if (ferr) exp_q.push_back('{cyc, 1, 16'h0001});
    if (ovr)  exp_q.push_back('{cyc, 2, 16'h0001});
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      cyc = cyc + 1;
      model_step();
    end
  end

  task automatic check_ev(input int kind, input logic [15:0] val);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL event: got kind=%0d val=%h at cycle %0d, expected no event", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.kind != kind || e.val !== val) begin
        miscompares++;
        $display("FAIL event: got kind=%0d val=%h cycle=%0d, expected kind=%0d val=%h cycle=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Monitor: every change of out and every FERR/OVR cycle is one observed event.
  initial begin
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (bus.out !== prev_out) begin
          check_ev(0, bus.out);
          prev_out = bus.out;
        end
        if (bus.FERR !== 1'b0) check_ev(1, {15'd0, bus.FERR});
        if (bus.OVR  !== 1'b0) check_ev(2, {15'd0, bus.OVR});
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic idle(input int n);
    bus.RX   = 1'b1;
    bus.load = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_load();
    bus.load = 1'b1;
    @(negedge CLK);
    bus.load = 1'b0;
    @(negedge CLK);
  endtask

  // One frame, bit t/B of {stop,data,start} per cycle; optional load or reset at offset t.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int load_t, input int rst_t);
    logic [9:0] bits;
    int n0;
    bits = {stop_ok, b, 1'b0};
    n0   = cyc;
    sched_q.push_back('{n0 + 9 * B + H + 3, b, stop_ok});
    for (int t = 0; t < 10 * B; t++) begin
      bus.RX   = bits[t / B];
      bus.load = (t == load_t);
      if (t == rst_t) begin
        RST_N    = 1'b0;
        bus.RX   = 1'b1;
        bus.load = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        return;
      end
      @(negedge CLK);
    end
    bus.load = 1'b0;
  endtask

  initial begin
    int gap;
    bit ok;
    bus.RX   = 1'b1;
    bus.load = 1'b0;
    RST_N    = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    chk("reset_out", bus.out, 16'h8000);
    chk("reset_ferr", {15'd0, bus.FERR}, 16'h0000);
    chk("reset_ovr", {15'd0, bus.OVR}, 16'h0000);
    mon_en = 1'b1;
    idle(20 * B);

    // 'R', clear, 'X', clear
    send_frame(8'h52, 1'b1, -1, -1);
    idle(H + 5);
    pulse_load();
    send_frame(8'h58, 1'b1, -1, -1);
    idle(H + 5);
    pulse_load();

    // glitch shorter than half a bit, then a framing error
    bus.RX = 1'b0;
    repeat ($urandom_range(1, H - 2)) @(negedge CLK);
    idle(2 * B);
    send_frame(8'hA5, 1'b0, -1, -1);
    idle(2 * B);

    // overrun, then the same pair with load in the commit cycle of the second byte
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1);
    idle(H + 5);
    repeat (CAP + 1) pulse_load();
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, 9 * B + H + 2, -1);
    idle(H + 5);
    repeat (CAP + 1) pulse_load();

    // five back-to-back bytes against the storage capacity, then drain
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1, -1);
    idle(H + 5);
    repeat (5) pulse_load();

    // randomized frames, stop bits, gaps and load strobes
    for (int i = 0; i < 30; i++) begin
      ok = ($urandom_range(0, 7) != 0);
      send_frame(8'($urandom), ok, ($urandom_range(0, 2) == 0) ? $urandom_range(0, 10 * B - 1) : -1, -1);
      gap = ok ? $urandom_range(0, B) : $urandom_range(2, B);
      idle(gap);
      if ($urandom_range(0, 3) == 0) pulse_load();
    end
    idle(B);
    repeat (CAP + 1) pulse_load();

    // reset during data bit 4 with a byte held, then the same frame in full
    send_frame(8'h77, 1'b1, -1, -1);
    idle(H + 5);
    send_frame(8'h3C, 1'b1, -1, 5 * B + H);
    chk("out_after_midframe_reset", bus.out, 16'h8000);
    idle(2 * B);
    send_frame(8'h3C, 1'b1, -1, -1);
    idle(H + 5);
    pulse_load();
    idle(3 * B);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_events: got %0d unobserved, expected 0 (next kind=%0d val=%h cycle=%0d)",
               exp_q.size(), exp_q[0].kind, exp_q[0].val, exp_q[0].cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
